motion_search_engine: RTL and testbench



---
 rtl/motion_search_engine.sv | 157 +++++++++++++++
 tb/tb_motion_search_engine.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/motion_search_engine.sv
// motion_search_engine: full-search SAD block matcher with partial-SAD pruning and early exit
// Ports: clock/reset_n (sync, active-low); start+threshold begin a search; addr_r/r_data and
// addr_s/s_data drive 1-cycle-latency reference and window memories; busy/done handshake;
// best_sad, motion_x, motion_y hold the best candidate until the next accepted start.
module motion_search_engine #(
  parameter int BLK = 16,
  parameter int RANGE = 8,
  parameter int PW = 8,
  parameter int ACCW = 16,
  localparam int SW = BLK + 2 * RANGE,
  localparam int VW = $clog2(RANGE) + 1,
  localparam int LB = $clog2(BLK),
  localparam int RAW = 2 * LB,
  localparam int SAW = $clog2(SW * SW)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic [ACCW-1:0] threshold,
  output logic [RAW-1:0]  addr_r,
  input  logic [PW-1:0]   r_data,
  output logic [SAW-1:0]  addr_s,
  input  logic [PW-1:0]   s_data,
  output logic            busy,
  output logic            done,
  output logic [ACCW-1:0] best_sad,
  output logic [VW-1:0]   motion_x,
  output logic [VW-1:0]   motion_y
);
  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, CMP, DONE} state_t;
  state_t state_q, state_d;
  logic [RAW-1:0] p_q, p_d;
  logic [VW-1:0] cx_q, cx_d, cy_q, cy_d, mx_q, mx_d, my_q, my_d;
  logic [SAW-1:0] as_q, as_d, rs, cs;
  logic [ACCW-1:0] acc_q, acc_d, best_q, best_d, thr_q, thr_d, acc_add, nbest;
  logic busy_q, busy_d, done_q, done_d, hit_q, hit_d, pr_q, pr_d;
  logic [PW:0] diff;
  logic [PW-1:0] mag;
  logic [ACCW:0] sum;
  logic upd, nhit, last_c, last_x, last_p, prune;
  always_comb begin
    diff = {1'b0, r_data} - {1'b0, s_data};
    mag = diff[PW] ? PW'(-diff) : diff[PW-1:0];
    sum = {1'b0, acc_q} + (ACCW+1)'(mag);
    acc_add = sum[ACCW] ? '1 : sum[ACCW-1:0];
    // acc_q holds at least one pixel once p_q reaches 2 (read latency of one cycle)
    prune = hit_q && p_q >= RAW'(2) && acc_q >= best_q;
    upd = !pr_q && (!hit_q || acc_q < best_q);
    nbest = upd ? acc_q : best_q;
    nhit = hit_q || upd;
    last_x = cx_q == VW'(2 * RANGE - 1);
    last_c = last_x && cy_q == VW'(2 * RANGE - 1);
    last_p = p_q == RAW'(BLK * BLK - 1);
    state_d = state_q;
    p_d = p_q;
    cx_d = cx_q;
    cy_d = cy_q;
    mx_d = mx_q;
    my_d = my_q;
    acc_d = acc_q;
    best_d = best_q;
    thr_d = thr_q;
    busy_d = busy_q;
    done_d = 1'b0;
    hit_d = hit_q;
    pr_d = pr_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SCAN;
        busy_d = 1'b1;
        thr_d = threshold;
        best_d = '1;
        hit_d = 1'b0;
        cx_d = '0;
        cy_d = '0;
        p_d = '0;
        acc_d = '0;
        pr_d = 1'b0;
      end
      SCAN: if (prune) begin
        state_d = CMP;
        pr_d = 1'b1;
      end else begin
        acc_d = p_q == '0 ? acc_q : acc_add;
        state_d = last_p ? DRAIN : SCAN;
        p_d = last_p ? p_q : p_q + RAW'(1);
      end
      DRAIN: begin
        acc_d = acc_add;
        state_d = CMP;
      end
      CMP: begin
        best_d = nbest;
        hit_d = nhit;
        mx_d = upd ? cx_q - VW'(RANGE) : mx_q;
        my_d = upd ? cy_q - VW'(RANGE) : my_q;
        if (last_c || (nhit && nbest <= thr_q)) begin
          state_d = DONE;
          done_d = 1'b1;
          busy_d = 1'b0;
        end else begin
          state_d = SCAN;
          cx_d = last_x ? '0 : cx_q + VW'(1);
          cy_d = last_x ? cy_q + VW'(1) : cy_q;
          p_d = '0;
          acc_d = '0;
          pr_d = 1'b0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rs = SAW'(p_d[RAW-1:LB]) + SAW'(cy_d);
    cs = SAW'(p_d[LB-1:0]) + SAW'(cx_d);
    as_d = rs * SAW'(SW) + cs;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      p_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
      mx_q <= '0;
      my_q <= '0;
      as_q <= '0;
      acc_q <= '0;
      best_q <= '1;
      thr_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hit_q <= 1'b0;
      pr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q <= p_d;
      cx_q <= cx_d;
      cy_q <= cy_d;
      mx_q <= mx_d;
      my_q <= my_d;
      as_q <= as_d;
      acc_q <= acc_d;
      best_q <= best_d;
      thr_q <= thr_d;
      busy_q <= busy_d;
      done_q <= done_d;
      hit_q <= hit_d;
      pr_q <= pr_d;
    end
  end
  assign addr_r = p_q;
  assign addr_s = as_q;
  assign busy = busy_q;
  assign done = done_q;
  assign best_sad = best_q;
  assign motion_x = mx_q;
  assign motion_y = my_q;
endmodule

// File: tb/tb_motion_search_engine.sv
// tb_motion_search_engine: table, directed and random checks of motion_search_engine
module tb_motion_search_engine;
  localparam int BLK = 4;
  localparam int RANGE = 2;
  localparam int PW = 8;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic start16 = 1'b0;
  logic start8 = 1'b0;
  logic [15:0] threshold = '0;
  logic [3:0] ar16, ar8;
  logic [5:0] as16, as8;
  logic [7:0] r16, s16, r8, s8;
  logic busy16, done16, busy8, done8;
  logic [15:0] best16;
  logic [7:0] best8;
  logic [1:0] mx16, my16, mx8, my8;
  logic [7:0] rmem [16];
  logic [7:0] wmem [64];
  int npass = 0;
  int ntot = 0;
  always #5 clock = ~clock;
  always @(posedge clock) begin
    r16 <= rmem[ar16];
    s16 <= wmem[as16];
    r8 <= rmem[ar8];
    s8 <= wmem[as8];
  end
  motion_search_engine #(.BLK(BLK), .RANGE(RANGE), .PW(PW), .ACCW(16)) u16 (
    .clock(clock), .reset_n(reset_n), .start(start16), .threshold(threshold),
    .addr_r(ar16), .r_data(r16), .addr_s(as16), .s_data(s16), .busy(busy16), .done(done16),
    .best_sad(best16), .motion_x(mx16), .motion_y(my16));
  motion_search_engine #(.BLK(BLK), .RANGE(RANGE), .PW(PW), .ACCW(8)) u8 (
    .clock(clock), .reset_n(reset_n), .start(start8), .threshold(threshold[7:0]),
    .addr_r(ar8), .r_data(r8), .addr_s(as8), .s_data(s8), .busy(busy8), .done(done8),
    .best_sad(best8), .motion_x(mx8), .motion_y(my8));
  typedef struct {
    int pat;
    bit w8;
    int thr;
    int sad;
    int mx;
    int my;
    int cyc;
  } vec_t;
  task automatic chk(input string nm, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask
  function automatic int osad(input bit w8);
    return w8 ? int'(best8) : int'(best16);
  endfunction
  function automatic int omx(input bit w8);
    logic [1:0] t;
    t = w8 ? mx8 : mx16;
    return int'($signed(t));
  endfunction
  function automatic int omy(input bit w8);
    logic [1:0] t;
    t = w8 ? my8 : my16;
    return int'($signed(t));
  endfunction
  task automatic fill(input int pat, input int ox, input int oy);
    for (int k = 0; k < 16; k++)
      rmem[k] = pat == 0 ? 8'(k) : pat == 4 ? 8'($urandom_range(0, 255)) : 8'd0;
    for (int i = 0; i < 64; i++)
      wmem[i] = pat == 1 ? 8'd3 : pat == 0 ? 8'd200 : pat == 4 ? 8'($urandom_range(0, 255)) : 8'd255;
    if (pat == 0 || pat >= 3)
      for (int k = 0; k < 16; k++)
        wmem[(k / 4 + oy + RANGE) * 8 + k % 4 + ox + RANGE] = rmem[k] ^ (pat == 4 ? 8'($urandom_range(0, 3)) : 8'd0);
  endtask
  // Reference: raster candidate search with saturating SADs, strict-less update,
  // first-candidate rule, threshold early exit, and per-candidate cycle cost
  // (full: BLK*BLK+2; pruned when the sum of pixels 0..p-2 reaches best at pixel p: p+2).
  function automatic void model(input int aw, input int thr, output int bsad, output int bx,
                                output int by, output int cyc);
    int maxv, len, a, b, d;
    int part [17];
    bit hit, stop, pr;
    maxv = (1 << aw) - 1;
    bsad = maxv; bx = 0; by = 0; cyc = 0; hit = 0; stop = 0;
    for (int dy = -RANGE; dy < RANGE && !stop; dy++)
      for (int dx = -RANGE; dx < RANGE && !stop; dx++) begin
        part[0] = 0;
        for (int k = 0; k < 16; k++) begin
          a = int'(rmem[k]);
          b = int'(wmem[(k / 4 + dy + RANGE) * 8 + k % 4 + dx + RANGE]);
          d = a > b ? a - b : b - a;
          part[k + 1] = part[k] + d > maxv ? maxv : part[k] + d;
        end
        len = 18; pr = 0;
        if (hit)
          for (int p = 2; p < 16 && !pr; p++)
            if (part[p - 1] >= bsad) begin len = p + 2; pr = 1; end
        if (!pr && (!hit || part[16] < bsad)) begin
          bsad = part[16]; bx = dx; by = dy; hit = 1;
        end
        cyc += len;
        if (hit && bsad <= thr) stop = 1;
      end
  endfunction
  task automatic run(input bit w8, input int thr, output int n);
    threshold = 16'(thr);
    if (w8) start8 = 1'b1;
    else start16 = 1'b1;
    @(posedge clock); #1;
    start16 = 1'b0; start8 = 1'b0;
    chk("busy_after_start", int'(w8 ? busy8 : busy16), 1);
    n = 0;
    while (!(w8 ? done8 : done16) && n < 3000) begin @(posedge clock); #1; n++; end
    chk("done_seen", int'(w8 ? done8 : done16), 1);
    chk("busy_low_at_done", int'(w8 ? busy8 : busy16), 0);
    @(posedge clock); #1;
    chk("done_single_pulse", int'(w8 ? done8 : done16), 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec_t tbl [4];
    int n, ms, mx, my, mc, ox, oy, thr;
    bit w8;
    tbl[0] = '{0, 1'b0, 0, 0, 1, -2, -1};
    tbl[1] = '{1, 1'b0, 0, 48, -2, -2, 288};
    tbl[2] = '{2, 1'b1, 0, 255, -2, -2, -1};
    tbl[3] = '{3, 1'b0, 0, 0, 1, 1, -1};
    fill(1, 0, 0);
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", int'(busy16), 0);
    chk("rst_done", int'(done16), 0);
    chk("rst_sad", int'(best16), 16'hFFFF);
    chk("rst_mx", omx(0), 0);
    chk("rst_my", omy(0), 0);
    chk("rst_addr_s", int'(as16), 0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) begin
      fill(tbl[i].pat, 1, tbl[i].pat == 0 ? -2 : 1);
      model(tbl[i].w8 ? 8 : 16, tbl[i].thr, ms, mx, my, mc);
      run(tbl[i].w8, tbl[i].thr, n);
      chk("tbl_sad", osad(tbl[i].w8), tbl[i].sad);
      chk("tbl_mx", omx(tbl[i].w8), tbl[i].mx);
      chk("tbl_my", omy(tbl[i].w8), tbl[i].my);
      chk("tbl_cycles_model", n, mc);
      if (tbl[i].cyc >= 0) chk("tbl_cycles_fixed", n, tbl[i].cyc);
      if (tbl[i].pat == 0) chk("early_exit_bound", int'(n <= 108), 1);
      if (tbl[i].pat == 3) chk("pruned_shorter", int'(n < 288), 1);
    end
    repeat (3) @(posedge clock);
    #1;
    chk("hold_sad", int'(best16), 0);
    chk("hold_mx", omx(0), 1);
    chk("hold_my", omy(0), 1);
    fill(1, 0, 0);
    threshold = '0;
    start16 = 1'b1;
    @(posedge clock); #1;
    start16 = 1'b0;
    repeat (7 * 18 + 4) @(posedge clock);
    #1;
    chk("mid_busy", int'(busy16), 1);
    reset_n = 1'b0;
    @(posedge clock); #1;
    chk("mid_rst_busy", int'(busy16), 0);
    chk("mid_rst_done", int'(done16), 0);
    chk("mid_rst_sad", int'(best16), 16'hFFFF);
    chk("mid_rst_mx", omx(0), 0);
    chk("mid_rst_my", omy(0), 0);
    chk("mid_rst_addr_r", int'(ar16), 0);
    chk("mid_rst_addr_s", int'(as16), 0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    start16 = 1'b1;
    @(posedge clock); #1;
    start16 = 1'b0;
    n = 0;
    repeat (10) begin @(posedge clock); #1; n++; end
    threshold = 16'd1000;
    start16 = 1'b1;
    @(posedge clock); #1;
    n++;
    start16 = 1'b0;
    threshold = '0;
    while (!done16 && n < 3000) begin @(posedge clock); #1; n++; end
    chk("ignored_start_cycles", n, 288);
    chk("ignored_start_sad", int'(best16), 48);
    @(posedge clock); #1;
    run(0, 100, n);
    chk("b2b1_cycles", n, 18);
    chk("b2b1_sad", int'(best16), 48);
    chk("b2b1_mx", omx(0), -2);
    run(0, 0, n);
    chk("b2b2_cycles", n, 288);
    chk("b2b2_sad", int'(best16), 48);
    for (int t = 0; t < 8; t++) begin
      w8 = 1'($urandom_range(0, 1));
      ox = $urandom_range(0, 3) - RANGE;
      oy = $urandom_range(0, 3) - RANGE;
      thr = $urandom_range(0, 40);
      fill(4, ox, oy);
      model(w8 ? 8 : 16, thr, ms, mx, my, mc);
      run(w8, thr, n);
      chk("rnd_sad", osad(w8), ms);
      chk("rnd_mx", omx(w8), mx);
      chk("rnd_my", omy(w8), my);
      chk("rnd_cycles", n, mc);
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
